noc_decoder_leaf: RTL and testbench
===================================

Name: noc_decoder_leaf

Overview:
- Leaf routing node of the NoC address-decoder tree.
- Accepts one flit per transfer, compares its address field with a fixed node address under a bit mask, and forwards the unmodified flit to Out0 (match) or Out1 (mismatch).
- Emits a 1-bit select token S per flit, so downstream logic can track the path taken.
- Clocked valid/ready implementation of the decoder stage; the gold model and the RTL must agree flit-for-flit.

Parameters:
- WIDTH, 9: flit width in bits.
- ADDR_W, 4: address field width; field = in_data[WIDTH-1 -: ADDR_W].
- ADDRESS, 4'b0000: node address compared against the flit address.
- MASK, 4'b1000: a 1 marks an address bit examined by this node.
- LEAF, 1: 1 = S channel active; 0 = S channel suppressed (s_valid held 0, S never blocks).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- _RESET  in  1  synchronous, active-low reset.
- in_valid  in  1  input flit valid.
- in_data  in  WIDTH  input flit.
- in_ready  out  1  input flit accepted when valid&ready.
- out0_valid  out  1  Out0 flit valid.
- out0_data  out  WIDTH  Out0 flit.
- out0_ready  in  1  Out0 consumer ready.
- out1_valid  out  1  Out1 flit valid.
- out1_data  out  WIDTH  Out1 flit.
- out1_ready  in  1  Out1 consumer ready.
- s_valid  out  1  select token valid.
- s_data  out  1  select token: 0 = Out0, 1 = Out1.
- s_ready  in  1  select consumer ready.

Behaviour:
- Interface: one clock CLK; reset _RESET is synchronous and active-low.
- Reset (_RESET=0 at an edge): out0/out1/s valid = 0, all data registers = 0, in_ready = 0. Flits held at reset are discarded. Operation resumes on the first edge after _RESET=1.
- Select: sel = |((in_data[WIDTH-1 -: ADDR_W] ^ ADDRESS) & MASK). sel=0 routes to Out0; sel=1 routes to Out1. MASK=0 routes everything to Out0.
- Storage: each of Out0, Out1 and S has a one-entry output register. Slot free = !valid | ready (same-cycle drain allowed).
- Accept: in_ready = _RESET & free(selected out) & (free(S) | !LEAF). in_ready is combinational from in_data/valids/readies and never depends on in_valid.
- On transfer: the selected register loads in_data and sets valid; the S register loads sel (if LEAF). Latency is 1 cycle; throughput is 1 flit/cycle when downstream is ready.
- Registers: each drains independently on valid&ready and clears valid unless reloaded in the same cycle. Data is stable while valid&!ready.
- Ordering: flits are delivered in order per output. The S token sequence matches the flit acceptance order.
- Head-of-line: a flit stalled for a full Out0 blocks later Out1 flits. No reordering.
- Payload: flit forwarded bit-exact; the address is not stripped.
- Simultaneous drain and load of the same register in one cycle: the new flit replaces the old, valid stays 1.

Optional Feature:
- Macro DECODER_FLIT_COUNT_EN.
- Defined: adds ports cnt0, cnt1 (out, 16 bits). Each counts flits accepted toward that output, wraps at 16'hFFFF→0, and clears on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package noc_decoder_pkg:
  - WIDTH/ADDR_W defaults and flit_t typedef.
  - Function route_sel(addr, address, mask) returning sel.
- Sub-module noc_chan_reg: parameterised one-entry valid/ready output register. Instantiated three times (Out0 WIDTH, Out1 WIDTH, S width 1).

Test Plan:
- Reset: _RESET=0 for 40 cycles with random in_valid → in_ready=0, all out valids 0; first flit after release is accepted.
- Route match: in_data=9'h0A5 (in[8]=0), all readies 1 → out0_data=9'h0A5, s_data=0 one cycle later; out1_valid stays 0.
- Route mismatch: in_data=9'h1A5 (in[8]=1) → out1_data=9'h1A5, s_data=1; bits [7:5] varied with in[8]=0 still route to Out0.
- Backpressure: out0_ready=0, send 9'h005 then 9'h006 → first held, in_ready=0 for second. Raise out0_ready → 9'h005 then 9'h006 in order, S = 0,0.
- S stall: s_ready=0 with one S token pending → in_ready=0 regardless of route. Release → continues without loss or duplication.
- Random cosim: 10k random 9-bit flits, random readies → S sequence and per-output data streams match the route_sel model exactly.

Source files
------------

// File: rtl/noc_decoder_pkg.sv
// rtl/noc_decoder_pkg.sv - shared widths, flit type and route select function for the NoC decoder leaf
package noc_decoder_pkg;

    localparam int WIDTH_DEF  = 9;
    localparam int ADDR_W_DEF = 4;

    typedef logic [WIDTH_DEF-1:0] flit_t;

    // 1 when any examined address bit differs from the node address.
    function automatic logic route_sel(
        input logic [ADDR_W_DEF-1:0] addr,
        input logic [ADDR_W_DEF-1:0] address,
        input logic [ADDR_W_DEF-1:0] mask
    );
        return |((addr ^ address) & mask);
    endfunction

endpackage

// File: rtl/noc_decoder_leaf_if.sv
// rtl/noc_decoder_leaf_if.sv - flit input, two flit outputs and select token channel bundle
interface noc_decoder_leaf_if
    import noc_decoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out0_valid;
    logic [WIDTH-1:0] out0_data;
    logic             out0_ready;
    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;
    logic             s_valid;
    logic             s_data;
    logic             s_ready;

    modport slave (
        input  in_valid, in_data, out0_ready, out1_ready, s_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, s_valid, s_data
    );

    modport master (
        output in_valid, in_data, out0_ready, out1_ready, s_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, s_valid, s_data
    );
endinterface

// File: rtl/noc_chan_reg.sv
// rtl/noc_chan_reg.sv - one-entry valid/ready output register with same-cycle drain and reload
module noc_chan_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         valid,
    output logic [W-1:0] data,
    input  logic         ready,
    output logic         free
);

    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_decoder_leaf.sv
// rtl/noc_decoder_leaf.sv - leaf decoder routing each flit to Out0/Out1 with a select token; DECODER_FLIT_COUNT_EN adds per-output flit counters
module noc_decoder_leaf
    import noc_decoder_pkg::*;
#(
    parameter int                WIDTH   = WIDTH_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] ADDRESS = 4'b0000,
    parameter logic [ADDR_W-1:0] MASK    = 4'b1000,
    parameter int                LEAF    = 1
) (
    input  logic CLK,
    input  logic _RESET,
    noc_decoder_leaf_if.slave bus
`ifdef DECODER_FLIT_COUNT_EN
    ,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
`endif
);

    localparam bit LEAF_EN = (LEAF != 0);

    logic sel;
    logic free0, free1, free_s;
    logic xfer;

    assign sel = route_sel(bus.in_data[WIDTH-1 -: ADDR_W], ADDRESS, MASK);

    // Acceptance never looks at in_valid, so upstream may wait on in_ready.
    assign bus.in_ready = _RESET && (sel ? free1 : free0) && (free_s || !LEAF_EN);
    assign xfer         = bus.in_valid && bus.in_ready;

    noc_chan_reg #(.W(WIDTH)) u_out0 (
        .clk       (CLK),
        .resetn    (_RESET),
        .load      (xfer && !sel),
        .load_data (bus.in_data),
        .valid     (bus.out0_valid),
        .data      (bus.out0_data),
        .ready     (bus.out0_ready),
        .free      (free0)
    );

    noc_chan_reg #(.W(WIDTH)) u_out1 (
        .clk       (CLK),
        .resetn    (_RESET),
        .load      (xfer && sel),
        .load_data (bus.in_data),
        .valid     (bus.out1_valid),
        .data      (bus.out1_data),
        .ready     (bus.out1_ready),
        .free      (free1)
    );

    noc_chan_reg #(.W(1)) u_sel (
        .clk       (CLK),
        .resetn    (_RESET),
        .load      (xfer && LEAF_EN),
        .load_data (sel),
        .valid     (bus.s_valid),
        .data      (bus.s_data),
        .ready     (bus.s_ready),
        .free      (free_s)
    );

`ifdef DECODER_FLIT_COUNT_EN
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (xfer) begin
            if (sel) cnt1 <= cnt1 + 16'd1;
            else     cnt0 <= cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_decoder_leaf.sv
// tb/tb_noc_decoder_leaf.sv - scoreboard bench for noc_decoder_leaf
`timescale 1ns/1ps
module tb_noc_decoder_leaf;

    logic CLK = 1'b0;
    logic _RESET = 1'b0;
    always #5 CLK = ~CLK;

    noc_decoder_leaf_if #(.WIDTH(9)) bus ();

`ifdef DECODER_FLIT_COUNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    noc_decoder_leaf dut (
        .CLK    (CLK),
        ._RESET (_RESET),
        .bus    (bus)
`ifdef DECODER_FLIT_COUNT_EN
        ,
        .cnt0   (cnt0),
        .cnt1   (cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic       exps[$];
    int n0 = 0;
    int n1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus: inputs set at negedge, acceptance judged before posedge.
    task automatic drive(input logic v, input logic [8:0] d, input logic r0, input logic r1,
                         input logic rs, output logic acc);
        @(negedge CLK);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        bus.s_ready    = rs;
        #1;
        acc = v && bus.in_ready;
        if (acc) begin
            if (d[8]) begin exp1.push_back(d); n1++; end
            else      begin exp0.push_back(d); n0++; end
            exps.push_back(d[8]);
        end
    endtask

    task automatic send(input logic [8:0] d, input logic r0, input logic r1, input logic rs);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) drive(1'b1, d, r0, r1, rs, acc);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: flit %0h not accepted in 50 cycles", d);
        end
    endtask

    // Monitor: pops expected values whenever an output handshake is about to complete.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (_RESET) begin
                if (bus.out0_valid && bus.out0_ready) begin
                    if (exp0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out0_unexpected: got %0h expected none", bus.out0_data);
                    end else check("out0_data", 32'(bus.out0_data), 32'(exp0.pop_front()));
                end
                if (bus.out1_valid && bus.out1_ready) begin
                    if (exp1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out1_unexpected: got %0h expected none", bus.out1_data);
                    end else check("out1_data", 32'(bus.out1_data), 32'(exp1.pop_front()));
                end
                if (bus.s_valid && bus.s_ready) begin
                    if (exps.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL s_unexpected: got %0h expected none", bus.s_data);
                    end else check("s_data", 32'(bus.s_data), 32'(exps.pop_front()));
                end
            end
        end
    end

    initial begin
        logic acc;
        bus.in_valid = 0; bus.in_data = '0;
        bus.out0_ready = 1; bus.out1_ready = 1; bus.s_ready = 1;

        // Reset held 40 cycles with random traffic: nothing accepted, nothing valid.
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 9'($urandom);
            #1;
            check("reset_in_ready", 32'(bus.in_ready), 32'd0);
            check("reset_valids", 32'({bus.out0_valid, bus.out1_valid, bus.s_valid}), 32'd0);
        end
        @(negedge CLK);
        bus.in_valid = 0;
        _RESET = 1'b1;

        // First flit after release and route match/mismatch.
        drive(1'b1, 9'h0A5, 1, 1, 1, acc);
        check("first_accept", 32'(acc), 32'd1);
        send(9'h1A5, 1, 1, 1);
        send(9'h0E5, 1, 1, 1);
        send(9'h045, 1, 1, 1);
        send(9'h1FF, 1, 1, 1);
        send(9'h000, 1, 1, 1);
        drive(1'b0, 9'h000, 1, 1, 1, acc);

        // Backpressure on Out0: second Out0 flit must wait, then both arrive in order.
        send(9'h005, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9'h006, 0, 1, 1, acc);
            check("bp_in_ready", 32'(acc), 32'd0);
        end
        drive(1'b1, 9'h006, 1, 1, 1, acc);
        check("bp_release_accept", 32'(acc), 32'd1);
        drive(1'b0, 9'h000, 1, 1, 1, acc);

        // S stall: pending token blocks both routes.
        send(9'h0A5, 1, 1, 0);
        drive(1'b1, 9'h0A6, 1, 1, 0, acc);
        check("sstall_out0_route", 32'(acc), 32'd0);
        drive(1'b1, 9'h1A6, 1, 1, 0, acc);
        check("sstall_out1_route", 32'(acc), 32'd0);
        send(9'h1A6, 1, 1, 1);
        send(9'h0A6, 1, 1, 1);

        // Random cosim.
        for (int i = 0; i < 10000; i++) begin
            logic [8:0] d;
            d = 9'($urandom);
            acc = 1'b0;
            for (int k = 0; k < 200 && !acc; k++) begin
                logic v;
                v = ($urandom_range(0, 7) != 0);
                drive(v, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0), acc);
            end
            if (!acc) begin
                errors++;
                $display("FAIL random_timeout: flit %0h not accepted", d);
                break;
            end
        end

        // Drain everything with a bounded wait.
        for (int i = 0; i < 100 && (exp0.size() + exp1.size() + exps.size()) != 0; i++)
            drive(1'b0, 9'h000, 1, 1, 1, acc);
        check("drain_empty", 32'(exp0.size() + exp1.size() + exps.size()), 32'd0);
        drive(1'b0, 9'h000, 1, 1, 1, acc);
        check("idle_valids", 32'({bus.out0_valid, bus.out1_valid, bus.s_valid}), 32'd0);
`ifdef DECODER_FLIT_COUNT_EN
        check("cnt0", 32'(cnt0), 32'(16'(n0)));
        check("cnt1", 32'(cnt1), 32'(16'(n1)));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
